hdmi_video_timing_overlay: RTL
==============================

Name: hdmi_video_timing_overlay

Overview:
- Parametrised HDMI video driver; successor to the fixed-format video driver.
- Generates H/V timing for any resolution and issues frame-buffer read requests that lead video_de by a configurable read latency.
- Produces three pixel modes: passthrough, colour bars, and passthrough with a motion bounding-box overlay.
- Sits between the frame-difference read FIFO and the DVI transmitter. Its outputs feed video_din, video_hsync, video_vsync and video_de directly.

Parameters:
H_SYNC, 40, hsync width (clocks)
H_BACK, 220, horizontal back porch
H_DISP, 1280, active pixels per line
H_FRONT, 110, horizontal front porch
V_SYNC, 5, vsync width (lines)
V_BACK, 20, vertical back porch
V_DISP, 720, active lines
V_FRONT, 5, vertical front porch
SYNC_POL, 0, sync active level (0 = active-low)
RD_LAT, 1, clocks from rd_en to valid rd_data (1..4)
DATA_W, 24, RGB width
COORD_W, 11, coordinate width
BOX_THICK, 2, overlay border thickness (pixels)
BOX_COLOR, 24'hFF0000, overlay colour

Ports:
hdmi_clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
mode  in  2  0 passthrough, 1 colour bars, 2 passthrough+box, 3 = 0
box_valid  in  1  one-cycle strobe: box_x0..box_y1 valid
box_x0  in  COORD_W  box left, inclusive
box_x1  in  COORD_W  box right, inclusive
box_y0  in  COORD_W  box top, inclusive
box_y1  in  COORD_W  box bottom, inclusive
rd_data  in  DATA_W  pixel data, valid RD_LAT clocks after rd_en
rd_en  out  1  pixel read request
pixel_xpos  out  COORD_W  active x of the requested pixel, 0 when rd_en=0
pixel_ypos  out  COORD_W  active y of the requested pixel, 0 when rd_en=0
video_hs  out  1  horizontal sync
video_vs  out  1  vertical sync
video_de  out  1  data enable
video_rgb  out  DATA_W  output pixel
frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0

Behaviour:
- Clock and reset: one clock, hdmi_clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - counters 0.
  - rd_en, video_de, video_rgb, pixel_xpos, pixel_ypos, frame_start = 0.
  - video_hs, video_vs = ~SYNC_POL.
  - shadow and active box invalid; active mode = 0.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters.
  - v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Raw timing:
  - hs_raw is asserted while h_cnt < H_SYNC.
  - vs_raw is asserted while v_cnt < V_SYNC.
  - de_raw is asserted while H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP and the equivalent V condition holds.
- Read request:
  - rd_en is de_raw registered, so it is high exactly H_DISP clocks per active line.
  - pixel_xpos/pixel_ypos are registered alongside rd_en.
  - rd_en is asserted in every mode, so the FIFO drain rate is mode-independent; rd_data is discarded in mode 1.
- Alignment:
  - hs, vs and de pass through an RD_LAT-deep shift register after the rd_en stage, then one output register.
  - Result: video_de rises RD_LAT+1 clocks after rd_en rises.
  - video_rgb carries the rd_data sampled RD_LAT clocks after the matching rd_en.
  - No bubbles inside a line.
- video_rgb is 0 whenever video_de = 0.
- Box shadowing:
  - A box_valid strobe captures all four coordinates into a shadow register; a new strobe overwrites it.
  - On frame_start, the shadow box and mode copy into the active registers.
  - Mid-frame changes never tear the image.
  - box_valid coincident with frame_start: the new values are used for the next frame, not the current one.
  - Box is invalid when x0 > x1 or y0 > y1; an invalid box draws no overlay.
- Overlay (mode 2):
  - A pixel at (x, y) is replaced with BOX_COLOR when it lies inside the box and is within BOX_THICK of any edge.
  - Boxes thinner than 2*BOX_THICK are drawn solid.
  - Coordinates beyond H_DISP/V_DISP are clipped implicitly.
- Colour bars (mode 1):
  - 8 vertical bars: white, yellow, cyan, green, magenta, red, blue, black.
  - Each bar is H_DISP/8 wide (integer); the remainder columns are black.
  - Bar index comes from a bar-width counter; no divider.
- Overlay and bar decisions use the x/y pipelined with the data, so colour and data are co-timed.
- Reset mid-frame: all state returns to reset values immediately. The first frame after release starts at h_cnt=0, v_cnt=0 with a frame_start pulse one clock after release.

Decomposition:
- Package hdmi_vid_pkg:
  - mode enum: MODE_PASS, MODE_BARS, MODE_BOX.
  - colour-bar RGB constant array.
  - box struct {x0, x1, y0, y1}.
  - function box_valid_f.
- Sub-module hdmi_timing_counter: H/V counters, raw hs/vs/de, active x/y, frame_start.
- Top: rd_en stage, alignment pipe, shadow registers, pixel mux.

Test Plan:
1. H 2/2/8/2, V 1/1/4/1, RD_LAT=1, mode 0, rd_data = x + 16·y:
   - rd_en high 8 clocks per active line.
   - video_de rises 2 clocks after rd_en.
   - video_rgb sequence 0..7, then 16..23.
   - Frame period 98 clocks.
2. Same timing, RD_LAT=3: video_de lags rd_en by 4 clocks; rgb/de alignment is unchanged.
3. mode 2, box (2,5,1,2), BOX_THICK=1, strobed mid-frame:
   - Current frame is unaffected.
   - Next frame: FF0000 at x=2..5 on y=1 and y=2; all other pixels pass through.
4. mode 1, H_DISP=16: pixel pairs show the 8 bar colours in order, white first, black last.
5. Box with x0=6 > x1=3 in mode 2: output identical to mode 0.
6. rst_n asserted mid-line for 3 clocks:
   - During reset: outputs at reset values asynchronously.
   - After release: frame_start 1 clock later; timing restarts from h_cnt=0.

Source files
------------

// File: rtl/hdmi_vid_pkg.sv
// Shared types and constants for the HDMI video timing / overlay driver.
package hdmi_vid_pkg;

    // Pixel source selection; encoding 3 is treated as passthrough.
    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_BARS = 2'd1,
        MODE_BOX  = 2'd2
    } mode_e;

    // Box coordinates are held at a fixed width wide enough for any raster
    // this driver targets; narrower coordinate ports zero-extend into it.
    localparam int BOX_CW = 16;

    typedef struct packed {
        logic [BOX_CW-1:0] x0;
        logic [BOX_CW-1:0] x1;
        logic [BOX_CW-1:0] y0;
        logic [BOX_CW-1:0] y1;
    } box_t;

    // Colour bars, left to right.
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF,   // white
        24'hFFFF00,   // yellow
        24'h00FFFF,   // cyan
        24'h00FF00,   // green
        24'hFF00FF,   // magenta
        24'hFF0000,   // red
        24'h0000FF,   // blue
        24'h000000    // black
    };

    // A box with inverted corners draws nothing.
    function automatic logic box_valid_f(input box_t b);
        return (b.x0 <= b.x1) && (b.y0 <= b.y1);
    endfunction

    // Map the raw mode input onto the enum, folding the spare code to passthrough.
    function automatic mode_e mode_decode_f(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_BARS;
            2'd2:    return MODE_BOX;
            default: return MODE_PASS;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// Free-running H/V raster counters with raw sync/enable decode and
// active-area coordinates. frame_start is registered so it is low in reset
// and pulses on the first clock after release.
module hdmi_timing_counter #(
    parameter int H_SYNC  = 40,
    parameter int H_BACK  = 220,
    parameter int H_DISP  = 1280,
    parameter int H_FRONT = 110,
    parameter int V_SYNC  = 5,
    parameter int V_BACK  = 20,
    parameter int V_DISP  = 720,
    parameter int V_FRONT = 5,
    parameter int COORD_W = 11
) (
    input  logic               hdmi_clk,
    input  logic               rst_n,
    output logic               hs_raw,
    output logic               vs_raw,
    output logic               de_raw,
    output logic [COORD_W-1:0] act_x,
    output logic [COORD_W-1:0] act_y,
    output logic               frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    // One extra count of headroom so the end-of-active compare never wraps.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_START_C = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_END_C   = HW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_START_C = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_END_C   = VW'(V_SYNC + V_BACK + V_DISP);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          frame_start_q;

    // Next raster position: h wraps every line, v advances on each h wrap.
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
    end

    // Counter and frame-start registers.
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= (h_q == '0) && (v_q == '0);
        end
    end

    assign hs_raw      = (h_q < H_SYNC_C);
    assign vs_raw      = (v_q < V_SYNC_C);
    assign de_raw      = (h_q >= H_START_C) && (h_q < H_END_C) &&
                         (v_q >= V_START_C) && (v_q < V_END_C);
    assign act_x       = COORD_W'(h_q - H_START_C);
    assign act_y       = COORD_W'(v_q - V_START_C);
    assign frame_start = frame_start_q;

endmodule

// File: rtl/hdmi_video_timing_overlay.sv
// Parametrised HDMI video driver: raster timing, frame-buffer read requests
// that lead video_de by RD_LAT+1 clocks, and a pixel mux for passthrough,
// colour bars and passthrough with a motion bounding-box overlay.
module hdmi_video_timing_overlay
    import hdmi_vid_pkg::*;
#(
    parameter int                H_SYNC    = 40,
    parameter int                H_BACK    = 220,
    parameter int                H_DISP    = 1280,
    parameter int                H_FRONT   = 110,
    parameter int                V_SYNC    = 5,
    parameter int                V_BACK    = 20,
    parameter int                V_DISP    = 720,
    parameter int                V_FRONT   = 5,
    parameter int                SYNC_POL  = 0,
    parameter int                RD_LAT    = 1,
    parameter int                DATA_W    = 24,
    parameter int                COORD_W   = 11,
    parameter int                BOX_THICK = 2,
    parameter logic [DATA_W-1:0] BOX_COLOR = 24'hFF0000
) (
    input  logic               hdmi_clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               box_valid,
    input  logic [COORD_W-1:0] box_x0,
    input  logic [COORD_W-1:0] box_x1,
    input  logic [COORD_W-1:0] box_y0,
    input  logic [COORD_W-1:0] box_y1,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               rd_en,
    output logic [COORD_W-1:0] pixel_xpos,
    output logic [COORD_W-1:0] pixel_ypos,
    output logic               video_hs,
    output logic               video_vs,
    output logic               video_de,
    output logic [DATA_W-1:0]  video_rgb,
    output logic               frame_start
);

    localparam logic               SYNC_ACT  = 1'(SYNC_POL);
    localparam logic               SYNC_IDLE = ~SYNC_ACT;
    localparam int                 BAR_W     = H_DISP / 8;
    localparam logic [COORD_W-1:0] BAR_LAST  = COORD_W'(BAR_W - 1);
    localparam logic [3:0]         BAR_NONE  = 4'd8;   // remainder columns
    localparam int                 OW        = BOX_CW + 2;
    localparam logic [OW-1:0]      THICK     = OW'(BOX_THICK);

    // Everything that must stay co-timed with the fetched pixel.
    typedef struct packed {
        logic               hs;
        logic               vs;
        logic               de;
        logic [3:0]         bar;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pix_t;

    logic               hs_raw, vs_raw, de_raw;
    logic [COORD_W-1:0] act_x, act_y;

    hdmi_timing_counter #(
        .H_SYNC (H_SYNC),  .H_BACK (H_BACK),  .H_DISP (H_DISP),  .H_FRONT(H_FRONT),
        .V_SYNC (V_SYNC),  .V_BACK (V_BACK),  .V_DISP (V_DISP),  .V_FRONT(V_FRONT),
        .COORD_W(COORD_W)
    ) u_timing (
        .hdmi_clk   (hdmi_clk),
        .rst_n      (rst_n),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .de_raw     (de_raw),
        .act_x      (act_x),
        .act_y      (act_y),
        .frame_start(frame_start)
    );

    // ---------------- read-request stage ----------------
    logic               rd_en_q;
    logic [COORD_W-1:0] xpos_q, ypos_q;
    logic               hs_s_q, vs_s_q;
    logic [COORD_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [3:0]         bar_idx_q, bar_idx_d;

    // Bar index tracked by a per-bar column counter restarted at each line start.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (de_raw) begin
            if (act_x == '0) begin
                bar_cnt_d = '0;
                bar_idx_d = (BAR_W == 0) ? BAR_NONE : 4'd0;
            end else if (bar_idx_q != BAR_NONE) begin
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 4'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + COORD_W'(1);
                end
            end
        end
    end

    // Register the raw timing into the request stage that drives rd_en.
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q   <= 1'b0;
            xpos_q    <= '0;
            ypos_q    <= '0;
            hs_s_q    <= 1'b0;
            vs_s_q    <= 1'b0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            rd_en_q   <= de_raw;
            xpos_q    <= de_raw ? act_x : '0;
            ypos_q    <= de_raw ? act_y : '0;
            hs_s_q    <= hs_raw;
            vs_s_q    <= vs_raw;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // ---------------- alignment pipe ----------------
    pix_t pipe_q [RD_LAT];
    pix_t stage0;
    pix_t tail;

    assign stage0 = '{hs: hs_s_q, vs: vs_s_q, de: rd_en_q, bar: bar_idx_q,
                      x: xpos_q, y: ypos_q};
    assign tail   = pipe_q[RD_LAT-1];

    // Delay timing and coordinates by RD_LAT so they meet the returning rd_data.
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= stage0;
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // ---------------- box / mode shadowing ----------------
    box_t  shadow_q, active_q;
    logic  shadow_vld_q, active_vld_q;
    mode_e active_mode_q;

    // Strobes land in the shadow; the frame boundary promotes shadow and mode
    // so a frame is always drawn with one consistent setting.
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            shadow_vld_q  <= 1'b0;
            active_q      <= '0;
            active_vld_q  <= 1'b0;
            active_mode_q <= MODE_PASS;
        end else begin
            if (frame_start) begin
                active_q      <= shadow_q;
                active_vld_q  <= shadow_vld_q;
                active_mode_q <= mode_decode_f(mode);
            end
            if (box_valid) begin
                shadow_q.x0  <= BOX_CW'(box_x0);
                shadow_q.x1  <= BOX_CW'(box_x1);
                shadow_q.y0  <= BOX_CW'(box_y0);
                shadow_q.y1  <= BOX_CW'(box_y1);
                shadow_vld_q <= 1'b1;
            end
        end
    end

    // ---------------- pixel mux ----------------
    logic [OW-1:0]     ex, ey, bx0, bx1, by0, by1;
    logic              in_box, on_border, box_hit;
    logic [DATA_W-1:0] rgb_d;

    // Border hit test; boxes thinner than two borders come out solid.
    always_comb begin
        ex        = OW'(tail.x);
        ey        = OW'(tail.y);
        bx0       = OW'(active_q.x0);
        bx1       = OW'(active_q.x1);
        by0       = OW'(active_q.y0);
        by1       = OW'(active_q.y1);
        in_box    = (ex >= bx0) && (ex <= bx1) && (ey >= by0) && (ey <= by1);
        on_border = (ex < bx0 + THICK) || (ex + THICK > bx1) ||
                    (ey < by0 + THICK) || (ey + THICK > by1);
        box_hit   = active_vld_q && box_valid_f(active_q) && in_box && on_border;
    end

    // Select the output colour; blanking forces black.
    always_comb begin
        rgb_d = '0;
        if (tail.de) begin
            case (active_mode_q)
                MODE_BARS: rgb_d = (tail.bar < BAR_NONE) ?
                                   DATA_W'(BAR_RGB[tail.bar[2:0]]) : '0;
                MODE_BOX:  rgb_d = box_hit ? BOX_COLOR : rd_data;
                default:   rgb_d = rd_data;
            endcase
        end
    end

    logic              video_hs_q, video_vs_q, video_de_q;
    logic [DATA_W-1:0] video_rgb_q;

    // Output register feeding the DVI transmitter.
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            video_hs_q  <= SYNC_IDLE;
            video_vs_q  <= SYNC_IDLE;
            video_de_q  <= 1'b0;
            video_rgb_q <= '0;
        end else begin
            video_hs_q  <= tail.hs ? SYNC_ACT : SYNC_IDLE;
            video_vs_q  <= tail.vs ? SYNC_ACT : SYNC_IDLE;
            video_de_q  <= tail.de;
            video_rgb_q <= rgb_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign pixel_xpos = xpos_q;
    assign pixel_ypos = ypos_q;
    assign video_hs   = video_hs_q;
    assign video_vs   = video_vs_q;
    assign video_de   = video_de_q;
    assign video_rgb  = video_rgb_q;

endmodule
